// File: rtl/lc3b_pipe_ctrl_pkg.sv
// Shared types for the LC-3b pipeline controller: the controller state encoding
// and the stall counter width.
package lc3b_types;

    localparam int STALL_CNT_W = 16;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        ISTALL = 2'd1,
        DSTALL = 2'd2,
        FLUSH  = 2'd3
    } lc3b_pipe_state;

endpackage

// File: rtl/lc3b_pipe_ctrl_scoreboard.sv
// Register busy vector: a bit is set when a writing instruction leaves decode
// and cleared at writeback. When both happen on the same bit, set wins.
module lc3b_scoreboard #(
    parameter int NUM_REGS = 8,
    parameter int REG_W    = $clog2(NUM_REGS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             set_en,
    input  logic [REG_W-1:0] set_idx,
    input  logic             clr_en,
    input  logic [REG_W-1:0] clr_idx,
    input  logic [REG_W-1:0] src_a,
    input  logic             src_a_en,
    input  logic [REG_W-1:0] src_b,
    input  logic             src_b_en,
    output logic             hit
);

    logic [NUM_REGS-1:0] busy_q;
    logic [NUM_REGS-1:0] busy_d;

    always_comb begin
        busy_d = busy_q;
        if (clr_en) busy_d[clr_idx] = 1'b0;
        if (set_en) busy_d[set_idx] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) busy_q <= '0;
        else        busy_q <= busy_d;
    end

    assign hit = (src_a_en & busy_q[src_a]) | (src_b_en & busy_q[src_b]);

endmodule

// File: rtl/lc3b_pipe_ctrl.sv
// LC-3b pipeline stall/flush controller. The optional register scoreboard
// (RAW interlock) is built only when PIPE_SCOREBOARD_EN is defined.
module lc3b_pipe_ctrl
    import lc3b_types::*;
#(
    parameter int NUM_STAGES = 5,
    parameter int MEM_STAGE  = 2,
    parameter int NUM_REGS   = 8,
    localparam int REG_W     = $clog2(NUM_REGS)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_mem_resp,
    input  logic                   d_req,
    input  logic                   d_mem_resp,
    input  logic                   redirect,
    input  logic [REG_W-1:0]       dec_src_a,
    input  logic [REG_W-1:0]       dec_src_b,
    input  logic                   dec_src_a_en,
    input  logic                   dec_src_b_en,
    input  logic [REG_W-1:0]       dec_dest,
    input  logic                   dec_we,
    input  logic [REG_W-1:0]       wb_dest,
    input  logic                   wb_we,
    output logic                   load_pc,
    output logic [NUM_STAGES-1:0]  stage_load,
    output logic [NUM_STAGES-1:0]  stage_valid,
    output logic                   dcache_enable,
    output logic [1:0]             ctrl_state,
    output logic [STALL_CNT_W-1:0] stall_cnt
);

    logic [NUM_STAGES-1:0]  valid_q, valid_d;
    logic [STALL_CNT_W-1:0] cnt_q, cnt_d;
    lc3b_pipe_state         state_q, state_d;

    logic                   dstall, redir, raw, istall;
    logic                   src_busy;
    logic                   sb_set;
    logic                   load_pc_c;
    logic [NUM_STAGES-1:0]  stage_load_c;

    always_comb begin
        dstall = valid_q[MEM_STAGE] & d_req & ~d_mem_resp;
        redir  = valid_q[MEM_STAGE] & redirect & ~dstall;
        raw    = valid_q[0] & src_busy & ~dstall & ~redir;
        istall = ~i_mem_resp & ~dstall & ~redir & ~raw;
        // only an instruction actually moving from stage 0 into stage 1 claims its destination
        sb_set = valid_q[0] & dec_we & ~dstall & ~redir & ~raw;

        load_pc_c    = 1'b1;
        stage_load_c = '1;
        valid_d[0]   = 1'b1;
        for (int i = 1; i < NUM_STAGES; i++) valid_d[i] = valid_q[i-1];
        state_d = RUN;

        if (dstall) begin
            load_pc_c = 1'b0;
            for (int i = 0; i <= MEM_STAGE; i++) begin
                stage_load_c[i] = 1'b0;
                valid_d[i]      = valid_q[i];
            end
            valid_d[MEM_STAGE+1] = 1'b0;
            state_d = DSTALL;
        end else if (redir) begin
            for (int i = 0; i <= MEM_STAGE; i++) valid_d[i] = 1'b0;
            valid_d[MEM_STAGE+1] = 1'b1;
            state_d = FLUSH;
        end else if (raw) begin
            load_pc_c       = 1'b0;
            stage_load_c[0] = 1'b0;
            valid_d[0]      = valid_q[0];
            valid_d[1]      = 1'b0;
            state_d = ISTALL;
        end else if (istall) begin
            load_pc_c  = 1'b0;
            valid_d[0] = 1'b0;
            state_d = ISTALL;
        end

        cnt_d = cnt_q;
        if (!load_pc_c && (cnt_q != {STALL_CNT_W{1'b1}})) cnt_d = cnt_q + STALL_CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            cnt_q   <= '0;
            state_q <= RUN;
        end else begin
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
            state_q <= state_d;
        end
    end

`ifdef PIPE_SCOREBOARD_EN
    lc3b_scoreboard #(
        .NUM_REGS (NUM_REGS),
        .REG_W    (REG_W)
    ) u_scoreboard (
        .clk      (clk),
        .rst_n    (rst_n),
        .set_en   (sb_set),
        .set_idx  (dec_dest),
        .clr_en   (wb_we),
        .clr_idx  (wb_dest),
        .src_a    (dec_src_a),
        .src_a_en (dec_src_a_en),
        .src_b    (dec_src_b),
        .src_b_en (dec_src_b_en),
        .hit      (src_busy)
    );
`else
    // forwarding handles hazards outside this block, so decode operands never stall
    logic unused_sb_inputs;
    assign src_busy         = 1'b0;
    assign unused_sb_inputs = ^{dec_src_a, dec_src_b, dec_src_a_en, dec_src_b_en,
                                dec_dest, dec_we, wb_dest, wb_we, sb_set};
`endif

    assign load_pc       = load_pc_c;
    assign stage_load    = stage_load_c;
    assign stage_valid   = valid_q;
    assign dcache_enable = d_req & valid_q[MEM_STAGE];
    assign ctrl_state    = state_q;
    assign stall_cnt     = cnt_q;

endmodule
